// File: rtl/fft_mag_pkg.sv
// fft_pkg: widths and constants shared by the FFT magnitude, log lookup and display stages.
package fft_pkg;

   localparam int MAG_W = 7;
   localparam logic [MAG_W-1:0] MAG_MAX = 7'd127;
   localparam int BIN_W = 7;
   localparam int ALPHA_SH = 2;
   localparam int BETA_SH = 3;

   function automatic logic [MAG_W-1:0] sat_mag(input logic [31:0] q);
      if (q > 32'(MAG_MAX)) begin
         return MAG_MAX;
      end else begin
         return MAG_W'(q);
      end
   endfunction

endpackage

// File: rtl/fft_mag_avg_ram.sv
// fft_mag_avg_ram: per-bin magnitude history, one write port and one registered read port.
// Contents are deliberately left unreset; the first frame after reset overwrites every bin.
module fft_mag_avg_ram
   import fft_pkg::*;
#(
   parameter int AW = BIN_W,
   parameter int DW = MAG_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Same-address write/read collisions are resolved by forwarding in the pipeline.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fft_mag.sv
// fft_mag: streaming |X| estimate (alpha-max-plus-beta-min), 3-stage valid/ready pipeline.
// Define FFT_MAG_AVG_EN to add per-bin frame-to-frame smoothing of the output magnitude.
module fft_mag
   import fft_pkg::*;
#(
   parameter int DW    = 16,
   parameter int BW    = BIN_W,
   parameter int SHIFT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DW-1:0]    s_re,
   input  logic [DW-1:0]    s_im,
   input  logic [BW-1:0]    s_bin,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [MAG_W-1:0] m_mag,
   output logic [BW-1:0]    m_bin,
   output logic             m_last
);

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   logic             en_s;
   logic [DW-1:0]    abs_re_s, abs_im_s, mx_s, mn_s;
   logic [DW:0]      sum_s, q_s;
   logic [MAG_W-1:0] mag_new_s, mag_out_s;

   logic             v1_r, v2_r;
   logic [DW-1:0]    a1_r, b1_r, mx2_r, mn2_r;
   logic [BW-1:0]    bin1_r, bin2_r;
   logic             last1_r, last2_r;

   assign en_s    = !m_valid || m_ready;
   assign s_ready = en_s;

   // Abs, max/min ordering and scaled saturating sum feeding the three stages.
   always_comb begin
      abs_re_s = s_re[DW-1] ? (~s_re + ONE) : s_re;
      abs_im_s = s_im[DW-1] ? (~s_im + ONE) : s_im;
      if (a1_r >= b1_r) begin
         mx_s = a1_r;
         mn_s = b1_r;
      end else begin
         mx_s = b1_r;
         mn_s = a1_r;
      end
      sum_s     = {1'b0, mx2_r} + {1'b0, mn2_r >> ALPHA_SH} + {1'b0, mn2_r >> BETA_SH};
      q_s       = sum_s >> SHIFT;
      mag_new_s = sat_mag(32'(q_s));
   end

`ifdef FFT_MAG_AVG_EN
   logic             out_fire_s, first_eff_s;
   logic             first_frame_r, fwd_rd_r;
   logic [MAG_W-1:0] fwd_val_r, ram_q_s, prev_s;
   logic [MAG_W:0]   avg_sum_s;

   assign out_fire_s = m_valid && m_ready;

   fft_mag_avg_ram #(
      .AW(BW),
      .DW(MAG_W)
   ) u_ram (
      .clk  (clk),
      .we   (out_fire_s),
      .waddr(m_bin),
      .wdata(m_mag),
      .re   (en_s),
      .raddr(bin1_r),
      .rdata(ram_q_s)
   );

   // Capture a same-bin write that lands on the RAM read edge, and track the first frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_rd_r      <= 1'b0;
         fwd_val_r     <= {MAG_W{1'b0}};
         first_frame_r <= 1'b1;
      end else begin
         if (en_s) begin
            fwd_rd_r  <= m_valid && (m_bin == bin1_r);
            fwd_val_r <= m_mag;
         end
         if (out_fire_s && m_last) begin
            first_frame_r <= 1'b0;
         end
      end
   end

   // Newest history for this bin: output register, read-edge forward, then RAM.
   always_comb begin
      first_eff_s = first_frame_r && !(m_valid && m_last);
      if (m_valid && (m_bin == bin2_r)) begin
         prev_s = m_mag;
      end else if (fwd_rd_r) begin
         prev_s = fwd_val_r;
      end else begin
         prev_s = ram_q_s;
      end
      avg_sum_s = {1'b0, prev_s} + {1'b0, mag_new_s};
      if (first_eff_s) begin
         mag_out_s = mag_new_s;
      end else begin
         mag_out_s = MAG_W'(avg_sum_s >> 1);
      end
   end
`else
   assign mag_out_s = mag_new_s;
`endif

   // All stages advance together; payload registers load only behind a valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r    <= 1'b0;
         a1_r    <= {DW{1'b0}};
         b1_r    <= {DW{1'b0}};
         bin1_r  <= {BW{1'b0}};
         last1_r <= 1'b0;
         v2_r    <= 1'b0;
         mx2_r   <= {DW{1'b0}};
         mn2_r   <= {DW{1'b0}};
         bin2_r  <= {BW{1'b0}};
         last2_r <= 1'b0;
         m_valid <= 1'b0;
         m_mag   <= {MAG_W{1'b0}};
         m_bin   <= {BW{1'b0}};
         m_last  <= 1'b0;
      end else if (en_s) begin
         v1_r <= s_valid;
         if (s_valid) begin
            a1_r    <= abs_re_s;
            b1_r    <= abs_im_s;
            bin1_r  <= s_bin;
            last1_r <= s_last;
         end
         v2_r <= v1_r;
         if (v1_r) begin
            mx2_r   <= mx_s;
            mn2_r   <= mn_s;
            bin2_r  <= bin1_r;
            last2_r <= last1_r;
         end
         m_valid <= v2_r;
         if (v2_r) begin
            m_mag  <= mag_out_s;
            m_bin  <= bin2_r;
            m_last <= last2_r;
         end
      end
   end

endmodule
